// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked add/subtract unit.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// N-bit ripple-carry adder built from a chain of full adders; also exposes carry into the MSB.
// Latency: combinational.
// Backpressure: none.
module rca_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic carry;

    always_comb begin
        carry = cin;
        s     = '0;
        c_msb = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) c_msb = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands summed CHUNK bits per clock through one shared adder.
// Latency: NCHUNK cycles from accept to out_valid; initiation interval NCHUNK+2.
// Backpressure: out_ready low holds DONE with stable outputs; in_ready only asserted in IDLE.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             carry_q, cout_q, ovf_q;
    logic [IW-1:0]    idx_q;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             chunk_cout, chunk_cmsb;
    logic             accept, last;
    int unsigned      base;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (idx_q == LAST_IDX) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign accept = in_valid && in_ready;
    assign last   = (idx_q == LAST_IDX);
    assign base   = int'(idx_q) * CHUNK;

    always_comb begin
        a_chunk = a_q[base +: CHUNK];
        b_chunk = b_q[base +: CHUNK];
    end

    rca_chunk #(.N(CHUNK)) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .s     (sum_chunk),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    // Subtraction folds into addition: a - b - cin == a + ~b + ~cin.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= cin ^ sub;
            idx_q   <= '0;
        end else if (state_q == ST_BUSY) begin
            s_q[base +: CHUNK] <= sum_chunk;
            carry_q <= chunk_cout;
            idx_q   <= last ? '0 : idx_q + IW'(1);
            if (last) begin
                cout_q <= chunk_cout;
                ovf_q  <= chunk_cout ^ chunk_cmsb;
            end
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder at 4/1, 16/4 and 8/8 WIDTH/CHUNK configurations.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, cin, sub, out_ready;
    logic [15:0] a, b;
    logic [1:0]  sel;

    logic        iv4, iv16, iv8, ir4, ir16, ir8, ov4, ov16, ov8;
    logic        c4, c16, c8, o4, o16, o8;
    logic [3:0]  s4;
    logic [15:0] s16;
    logic [7:0]  s8;

    assign iv4  = in_valid && (sel == 2'd0);
    assign iv16 = in_valid && (sel == 2'd1);
    assign iv8  = in_valid && (sel == 2'd2);

    seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) u4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .a(a[3:0]), .b(b[3:0]),
        .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(out_ready), .s(s4), .cout(c4), .ovf(o4));

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .s(s16), .cout(c16), .ovf(o16));

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(out_ready), .s(s8), .cout(c8), .ovf(o8));

    logic        obs_ir, obs_ov, obs_c, obs_o;
    logic [15:0] obs_s;

    always_comb begin
        obs_ir = ir16; obs_ov = ov16; obs_c = c16; obs_o = o16; obs_s = s16;
        case (sel)
            2'd0: begin obs_ir = ir4; obs_ov = ov4; obs_c = c4; obs_o = o4; obs_s = {12'h000, s4}; end
            2'd2: begin obs_ir = ir8; obs_ov = ov8; obs_c = c8; obs_o = o8; obs_s = {8'h00, s8}; end
            default: ;
        endcase
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int k, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tcin, input logic tsub, input logic [15:0] es,
                       input logic ec, input logic eo, input int elat, input int hold,
                       input string tag);
        int n;
        int lat;
        sel = k[1:0];
        n = 0;
        while (!obs_ir && n < 20) begin @(posedge clk); #1; n++; end
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        // scramble operands so any post-accept sampling corrupts the result
        in_valid = 1'b0; a = ~ta; b = ~tb_; cin = ~tcin; sub = ~tsub;
        lat = 0;
        while (!obs_ov && lat < 64) begin @(posedge clk); #1; lat++; end
        chk({tag, "_lat"}, lat, elat);
        for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
        chk({tag, "_ov"},   {31'd0, obs_ov}, 1);
        chk({tag, "_s"},    {16'd0, obs_s}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, obs_c}, {31'd0, ec});
        chk({tag, "_ovf"},  {31'd0, obs_o}, {31'd0, eo});
        chk({tag, "_ir_done"}, {31'd0, obs_ir}, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ov_rel"}, {31'd0, obs_ov}, 0);
        chk({tag, "_ir_rel"}, {31'd0, obs_ir}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0]  r8a, r8b;
    logic [8:0]  r8sum;
    logic [15:0] ra, rb, rs;
    logic [16:0] rwide;
    logic        rc, rsub, rco, rov;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        a = '0; b = '0; sel = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ir",   {31'd0, obs_ir}, 1);
        chk("rst_ov",   {31'd0, obs_ov}, 0);
        chk("rst_s",    {16'd0, obs_s}, 0);
        chk("rst_cout", {31'd0, obs_c}, 0);
        chk("rst_ovf",  {31'd0, obs_o}, 0);
        reset = 1'b0;

        run(0, 16'h000F, 16'h000A, 1'b0, 1'b0, 16'h0009, 1'b1, 1'b0, 4, 0, "w4_add");
        run(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 0, "w16_wrap");
        run(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, 0, "w16_ovf");
        run(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, 0, "sub_neg");
        run(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, 0, "sub_ovf");
        run(1, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 4, 10, "bp");

        // abort mid-BUSY at idx==2, with chunks 0 and 1 of s already written
        sel = 2'd1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ir", {31'd0, obs_ir}, 1);
        chk("abort_ov", {31'd0, obs_ov}, 0);
        chk("abort_s",  {16'd0, obs_s}, 0);
        run(1, 16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0, 4, 0, "post_abort");

        run(2, 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 0, "w8_ovf");

        for (int i = 0; i < 6; i++) begin
            r8a = 8'($urandom_range(0, 255));
            r8b = 8'($urandom_range(0, 255));
            rc  = 1'($urandom_range(0, 1));
            r8sum = {1'b0, r8a} + {1'b0, r8b} + {8'd0, rc};
            rov = (r8a[7] == r8b[7]) && (r8sum[7] != r8a[7]);
            run(2, {8'h00, r8a}, {8'h00, r8b}, rc, 1'b0, {8'h00, r8sum[7:0]}, r8sum[8], rov, 1, 0, "rnd8");
        end

        for (int i = 0; i < 6; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            if (rsub) begin
                rs  = ra - rb - {15'd0, rc};
                rco = ({1'b0, ra} >= ({1'b0, rb} + {16'd0, rc}));
                rov = (ra[15] != rb[15]) && (rs[15] != ra[15]);
            end else begin
                rwide = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
                rs  = rwide[15:0];
                rco = rwide[16];
                rov = (ra[15] == rb[15]) && (rs[15] != ra[15]);
            end
            run(1, ra, rb, rc, rsub, rs, rco, rov, 4, 0, "rnd16");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
